// File: rtl/dmem_responder_pkg.sv
// Shared memory-side definitions: responder states, byte-lane constants
// and the address checks reused by the instruction-memory side.
package mips_mem_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } rsp_state_e;

    localparam int         WORD_BYTES = 4;
    localparam logic [3:0] BE_FULL    = 4'b1111;
    localparam int         WS_MAX     = 15;

    function automatic logic addr_aligned(input logic [31:0] addr);
        return addr[1:0] == 2'b00;
    endfunction

    function automatic logic addr_in_range(
        input logic [31:0] addr,
        input int          depth_log2
    );
        return (addr >> (depth_log2 + 2)) == 32'd0;
    endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// Load/store request and response channels between datapath and data memory.
interface dmem_responder_if;

    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_be;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    modport master (
        output req_valid, req_write, req_addr, req_wdata, req_be, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata, req_be, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );

endinterface

// File: rtl/dmem_array.sv
// Word-organised storage with byte-enabled synchronous write and a
// registered read port; contents are never reset.
module dmem_array
    import mips_mem_pkg::*;
#(
    parameter int DEPTH_LOG2 = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_we,
    input  logic                  i_re,
    input  logic [3:0]            i_be,
    input  logic [DEPTH_LOG2-1:0] i_idx,
    input  logic [31:0]           i_wdata,
    output logic [31:0]           o_rdata
);

    logic [31:0] r_mem [2**DEPTH_LOG2];
    logic [31:0] r_rdata;

    always_ff @(posedge clk) begin
        if (i_we) begin
            if (i_be == BE_FULL) begin
                r_mem[i_idx] <= i_wdata;
            end else begin
                for (int i = 0; i < WORD_BYTES; i++) begin
                    if (i_be[i]) begin
                        r_mem[i_idx][8*i +: 8] <= i_wdata[8*i +: 8];
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rdata <= '0;
        end else if (i_re) begin
            r_rdata <= r_mem[i_idx];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: accepts one load/store at a time, inserts
// WAIT_STATES cycles, then holds a single response until it is taken.
module dmem_responder
    import mips_mem_pkg::*;
#(
    parameter int DEPTH_LOG2  = 8,
    parameter int WAIT_STATES = 2
) (
    input  logic       clk,
    input  logic       reset,
    dmem_responder_if.slave bus
);

    if (WAIT_STATES < 0 || WAIT_STATES > WS_MAX) begin : g_ws_check
        $error("dmem_responder: WAIT_STATES must be 0..15");
    end

    localparam logic [3:0] WS_LOAD = 4'(WAIT_STATES - 1);

    rsp_state_e  r_state;
    rsp_state_e  w_next;
    logic [3:0]  r_cnt;
    logic [3:0]  w_cnt_next;
    logic        r_req_ready;
    logic        r_write;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [3:0]  r_be;

    logic        w_accept;
    logic        w_enter_resp;
    logic        w_idle;
    logic        w_write;
    logic [31:0] w_addr;
    logic [31:0] w_wdata;
    logic [3:0]  w_be;
    logic        w_err;
    logic        w_rsp_valid;
    logic [31:0] w_arr_rdata;

    assign w_accept = bus.req_valid && r_req_ready;
    assign w_idle   = (r_state == IDLE);

    // With zero wait states RESP is entered straight from IDLE, so the
    // live request, not the latched copy, addresses the array.
    assign w_write = w_idle ? bus.req_write : r_write;
    assign w_addr  = w_idle ? bus.req_addr  : r_addr;
    assign w_wdata = w_idle ? bus.req_wdata : r_wdata;
    assign w_be    = w_idle ? bus.req_be    : r_be;

    assign w_err = !addr_aligned(w_addr) ||
                   !addr_in_range(w_addr, DEPTH_LOG2);

    always_comb begin
        w_next     = r_state;
        w_cnt_next = r_cnt;
        unique case (r_state)
            IDLE: begin
                if (w_accept) begin
                    if (WAIT_STATES == 0) begin
                        w_next = RESP;
                    end else begin
                        w_next     = WAIT;
                        w_cnt_next = WS_LOAD;
                    end
                end
            end
            WAIT: begin
                if (r_cnt == 4'd0) begin
                    w_next = RESP;
                end else begin
                    w_cnt_next = r_cnt - 4'd1;
                end
            end
            RESP: begin
                if (bus.rsp_ready) begin
                    w_next = IDLE;
                end
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    assign w_enter_resp = (w_next == RESP) && (r_state != RESP);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_req_ready <= 1'b0;
            r_write     <= 1'b0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_be        <= '0;
        end else begin
            r_state     <= w_next;
            r_cnt       <= w_cnt_next;
            r_req_ready <= (w_next == IDLE);
            if (w_accept) begin
                r_write <= bus.req_write;
                r_addr  <= bus.req_addr;
                r_wdata <= bus.req_wdata;
                r_be    <= bus.req_be;
            end
        end
    end

    dmem_array #(
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_array (
        .clk     (clk),
        .rst_n   (reset),
        .i_we    (w_enter_resp && w_write && !w_err),
        .i_re    (w_enter_resp && !w_write && !w_err),
        .i_be    (w_be),
        .i_idx   (w_addr[DEPTH_LOG2+1:2]),
        .i_wdata (w_wdata),
        .o_rdata (w_arr_rdata)
    );

    assign w_rsp_valid   = (r_state == RESP);
    assign bus.req_ready = r_req_ready;
    assign bus.rsp_valid = w_rsp_valid;
    assign bus.rsp_err   = w_rsp_valid && w_err;
    assign bus.rsp_rdata = (w_rsp_valid && !w_write && !w_err) ?
                           w_arr_rdata : 32'd0;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: a cycle-level behavioural model checks the
// WAIT_STATES=2 instance; a second instance checks zero-wait throughput.
module tb_dmem_responder;

    localparam int WA = 2;

    logic clk   = 1'b0;
    logic rst_a = 1'b0;
    logic rst_b = 1'b0;
    int   tests = 0;
    int   fails = 0;
    int   cyc   = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    dmem_responder_if ifa ();
    dmem_responder_if ifb ();

    dmem_responder #(.DEPTH_LOG2(8), .WAIT_STATES(WA)) u_dut_a (
        .clk   (clk),
        .reset (rst_a),
        .bus   (ifa)
    );

    dmem_responder #(.DEPTH_LOG2(8), .WAIT_STATES(0)) u_dut_b (
        .clk   (clk),
        .reset (rst_b),
        .bus   (ifb)
    );

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, want %h", nm, act, exp);
        end
    endtask

    task automatic timeout(input string nm);
        tests++;
        fails++;
        $display("FAIL %s: wait bound expired at cycle %0d", nm, cyc);
    endtask

    // Behavioural model of instance A: one outstanding request, the
    // response appears WA+1 cycles after accept; storage updated on response.
    logic [31:0] m_mem [int];
    logic        m_busy = 1'b0;
    logic        m_done = 1'b0;
    logic        m_skip = 1'b1;
    int          m_left = 0;
    int          m_wi   = 0;
    logic        m_w    = 1'b0;
    logic [31:0] m_addr = '0;
    logic [31:0] m_wdata = '0;
    logic [3:0]  m_be   = '0;
    logic        m_err  = 1'b0;
    logic [31:0] m_rdata = '0;
    logic [31:0] m_v    = '0;

    always @(negedge clk) begin
        if (!rst_a) begin
            chk("rst_req_ready", {31'd0, ifa.req_ready}, 32'd0);
            chk("rst_rsp_valid", {31'd0, ifa.rsp_valid}, 32'd0);
            chk("rst_rsp_rdata", ifa.rsp_rdata, 32'd0);
            chk("rst_rsp_err",   {31'd0, ifa.rsp_err}, 32'd0);
            m_busy = 1'b0;
            m_done = 1'b0;
            m_skip = 1'b1;
        end else if (m_skip) begin
            m_skip = 1'b0;
        end else begin
            chk("m_req_ready", {31'd0, ifa.req_ready}, {31'd0, !m_busy});
            if (m_busy && m_left == 0 && !m_done) begin
                m_done  = 1'b1;
                m_err   = (m_addr % 4 != 0) || (m_addr >= 32'd1024);
                m_wi    = int'(m_addr / 4);
                m_rdata = 32'd0;
                if (!m_err && m_w) begin
                    m_v = m_mem.exists(m_wi) ? m_mem[m_wi] : 'x;
                    for (int b = 0; b < 4; b++)
                        if (m_be[b]) m_v[8*b +: 8] = m_wdata[8*b +: 8];
                    m_mem[m_wi] = m_v;
                end else if (!m_err) begin
                    m_rdata = m_mem.exists(m_wi) ? m_mem[m_wi] : 'x;
                end
            end
            chk("m_rsp_valid", {31'd0, ifa.rsp_valid},
                {31'd0, m_busy && m_left == 0});
            if (m_busy && m_left == 0) begin
                chk("m_rsp_err", {31'd0, ifa.rsp_err}, {31'd0, m_err});
                if (!$isunknown(m_rdata))
                    chk("m_rsp_rdata", ifa.rsp_rdata, m_rdata);
            end
            if (m_busy && m_left == 0 && ifa.rsp_ready) begin
                m_busy = 1'b0;
            end else if (m_busy && m_left > 0) begin
                m_left--;
            end else if (!m_busy && ifa.req_valid) begin
                m_busy  = 1'b1;
                m_done  = 1'b0;
                m_left  = WA;
                m_w     = ifa.req_write;
                m_addr  = ifa.req_addr;
                m_wdata = ifa.req_wdata;
                m_be    = ifa.req_be;
            end
        end
    end

    task automatic req_a(input logic w, input logic [31:0] a,
                         input logic [31:0] d, input logic [3:0] be,
                         input int hold, output logic [31:0] rd,
                         output logic er);
        int n;
        int lat;
        n = 0;
        ifa.req_write = w;
        ifa.req_addr  = a;
        ifa.req_wdata = d;
        ifa.req_be    = be;
        ifa.req_valid = 1'b1;
        while (ifa.req_ready !== 1'b1 && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 20) timeout("accept_wait");
        @(posedge clk); #1;
        ifa.req_valid = 1'b0;
        lat = 1;
        while (ifa.rsp_valid !== 1'b1 && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        if (lat >= 20) timeout("rsp_wait");
        chk("latency", lat, WA + 1);
        rd = ifa.rsp_rdata;
        er = ifa.rsp_err;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            chk("hold_rsp_valid", {31'd0, ifa.rsp_valid}, 32'd1);
            chk("hold_req_ready", {31'd0, ifa.req_ready}, 32'd0);
        end
        ifa.rsp_ready = 1'b1;
        @(posedge clk); #1;
        ifa.rsp_ready = 1'b0;
        chk("post_hs_req_ready", {31'd0, ifa.req_ready}, 32'd1);
        chk("post_hs_rsp_valid", {31'd0, ifa.rsp_valid}, 32'd0);
    endtask

    // Instance B monitors: accept and response cycles.
    int          acc_q [$];
    int          rsp_q [$];
    logic [31:0] rdq   [$];
    logic        errq  [$];

    always @(negedge clk) begin
        if (rst_b) begin
            if (ifb.req_valid && ifb.req_ready) acc_q.push_back(cyc);
            if (ifb.rsp_valid && ifb.rsp_ready) begin
                rsp_q.push_back(cyc);
                rdq.push_back(ifb.rsp_rdata);
                errq.push_back(ifb.rsp_err);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] rd;
        logic        er;
        logic [31:0] b_addr [4];
        logic [31:0] b_data [4];
        logic        b_w    [4];
        logic [31:0] b_exp  [4];
        int          k;
        logic        acc;
        int          nb;

        b_addr = '{32'h0, 32'h4, 32'h0, 32'h4};
        b_data = '{32'hCAFEF00D, 32'h0BADC0DE, 32'h0, 32'h0};
        b_w    = '{1'b1, 1'b1, 1'b0, 1'b0};
        b_exp  = '{32'h0, 32'h0, 32'hCAFEF00D, 32'h0BADC0DE};

        ifa.req_valid = 0; ifa.req_write = 0; ifa.req_addr = '0;
        ifa.req_wdata = '0; ifa.req_be = '0; ifa.rsp_ready = 0;
        ifb.req_valid = 0; ifb.req_write = 0; ifb.req_addr = '0;
        ifb.req_wdata = '0; ifb.req_be = '0; ifb.rsp_ready = 1;

        repeat (3) @(posedge clk); #1;
        chk("reset_req_ready_b", {31'd0, ifb.req_ready}, 32'd0);
        rst_a = 1'b1;
        rst_b = 1'b1;
        repeat (2) @(posedge clk); #1;
        chk("idle_req_ready", {31'd0, ifa.req_ready}, 32'd1);

        req_a(1, 32'h10, 32'hDEADBEEF, 4'hF, 0, rd, er);
        chk("st10_err", {31'd0, er}, 32'd0);
        chk("st10_rdata", rd, 32'd0);
        req_a(0, 32'h10, 32'h0, 4'h0, 0, rd, er);
        chk("ld10_full", rd, 32'hDEADBEEF);
        req_a(1, 32'h10, 32'h000000AA, 4'h1, 0, rd, er);
        req_a(0, 32'h10, 32'h0, 4'h0, 0, rd, er);
        chk("ld10_byte", rd, 32'hDEADBEAA);

        req_a(1, 32'h0, 32'h12345678, 4'hF, 0, rd, er);
        req_a(0, 32'h12, 32'h0, 4'h0, 0, rd, er);
        chk("misalign_err", {31'd0, er}, 32'd1);
        chk("misalign_rdata", rd, 32'd0);
        req_a(1, 32'h400, 32'hFFFFFFFF, 4'hF, 0, rd, er);
        chk("range_err", {31'd0, er}, 32'd1);
        req_a(0, 32'h0, 32'h0, 4'h0, 0, rd, er);
        chk("ld0_unchanged", rd, 32'h12345678);
        chk("ld0_err", {31'd0, er}, 32'd0);

        req_a(0, 32'h10, 32'h0, 4'h0, 4, rd, er);
        chk("ld10_hold", rd, 32'hDEADBEAA);

        req_a(1, 32'h20, 32'h11111111, 4'hF, 0, rd, er);
        req_a(1, 32'h20, 32'hFFFFFFFF, 4'h0, 0, rd, er);
        chk("be0_err", {31'd0, er}, 32'd0);
        req_a(0, 32'h20, 32'h0, 4'h0, 0, rd, er);
        chk("be0_noop", rd, 32'h11111111);

        // Reset during the wait window of a store: nothing may commit.
        ifa.req_write = 1; ifa.req_addr = 32'h20;
        ifa.req_wdata = 32'h22222222; ifa.req_be = 4'hF;
        ifa.req_valid = 1;
        nb = 0;
        while (ifa.req_ready !== 1'b1 && nb < 20) begin
            @(posedge clk); #1;
            nb++;
        end
        if (nb >= 20) timeout("rst_accept_wait");
        @(posedge clk); #1;
        ifa.req_valid = 0;
        @(posedge clk); #1;
        rst_a = 1'b0;
        #1;
        chk("midrst_req_ready", {31'd0, ifa.req_ready}, 32'd0);
        chk("midrst_rsp_valid", {31'd0, ifa.rsp_valid}, 32'd0);
        chk("midrst_rsp_rdata", ifa.rsp_rdata, 32'd0);
        chk("midrst_rsp_err",   {31'd0, ifa.rsp_err}, 32'd0);
        repeat (2) @(posedge clk); #1;
        rst_a = 1'b1;
        repeat (2) @(posedge clk); #1;
        req_a(0, 32'h20, 32'h0, 4'h0, 0, rd, er);
        chk("ld20_after_rst", rd, 32'h11111111);

        // Zero wait states, rsp_ready tied high: accept every other cycle.
        k = 0;
        ifb.req_write = b_w[0]; ifb.req_addr = b_addr[0];
        ifb.req_wdata = b_data[0]; ifb.req_be = 4'hF;
        ifb.req_valid = 1;
        for (int c = 0; c < 40 && k < 4; c++) begin
            @(negedge clk);
            acc = ifb.req_valid && ifb.req_ready;
            @(posedge clk); #1;
            if (acc) begin
                k++;
                if (k < 4) begin
                    ifb.req_write = b_w[k];
                    ifb.req_addr  = b_addr[k];
                    ifb.req_wdata = b_data[k];
                end else begin
                    ifb.req_valid = 0;
                end
            end
        end
        if (k < 4) timeout("b_accept_wait");
        repeat (3) @(posedge clk); #1;
        chk("b_accepts", acc_q.size(), 32'd4);
        chk("b_responses", rsp_q.size(), 32'd4);
        nb = (acc_q.size() < rsp_q.size()) ? acc_q.size() : rsp_q.size();
        if (nb > 4) nb = 4;
        for (int i = 0; i < nb; i++) begin
            chk("b_latency", rsp_q[i] - acc_q[i], 32'd1);
            chk("b_rdata", rdq[i], b_exp[i]);
            chk("b_err", {31'd0, errq[i]}, 32'd0);
            if (i > 0) chk("b_spacing", acc_q[i] - acc_q[i-1], 32'd2);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
